// File: rtl/hdb3_encoder.sv
// HDB3 line encoder: NRZ in, two-rail bipolar symbols out.
// A three-deep lookahead pipeline lets a four-zero window be rewritten as B00V or 000V.
module hdb3_encoder #(
    parameter logic INIT_LAST_POL = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_data,
    output logic [1:0] o_hdb3_code,
    output logic       o_valid
);

    typedef enum logic [1:0] {
        SYM_ZERO = 2'd0,
        SYM_MARK = 2'd1,
        SYM_B    = 2'd2,
        SYM_V    = 2'd3
    } sym_t;

    // Polarity 1 means a positive pulse on the plus rail.
    function automatic logic [1:0] pulse_code(input logic pol);
        logic [1:0] code;
        if (pol) begin
            code = 2'b10;
        end else begin
            code = 2'b01;
        end
        return code;
    endfunction

    sym_t       p1_q, p1_d;
    sym_t       p2_q, p2_d;
    sym_t       p3_q, p3_d;
    logic [1:0] fill_q, fill_d;
    logic       parity_q, parity_d;
    logic       last_pol_q, last_pol_d;
    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;

    logic       subst_s;
    sym_t       out_sym_s;

    // Substitution detection and the symbol leaving the pipeline this enable.
    always_comb begin
        subst_s = (fill_q == 2'd3) && (i_data == 1'b0) &&
                  (p1_q == SYM_ZERO) && (p2_q == SYM_ZERO) && (p3_q == SYM_ZERO);
        out_sym_s = p3_q;
        if (subst_s && (parity_q == 1'b0)) begin
            out_sym_s = SYM_B;
        end else begin
            out_sym_s = p3_q;
        end
    end

    // Next-state for pipeline, fill, parity, polarity and the output register.
    always_comb begin
        p1_d       = p1_q;
        p2_d       = p2_q;
        p3_d       = p3_q;
        fill_d     = fill_q;
        parity_d   = parity_q;
        last_pol_d = last_pol_q;
        code_d     = code_q;
        valid_d    = valid_q;

        if (i_en) begin
            if (subst_s) begin
                p1_d = SYM_V;
            end else if (i_data) begin
                p1_d = SYM_MARK;
            end else begin
                p1_d = SYM_ZERO;
            end
            p2_d = p1_q;
            p3_d = p2_q;

            if (fill_q == 2'd3) begin
                fill_d = 2'd3;
            end else begin
                fill_d = fill_q + 2'd1;
            end

            if (subst_s) begin
                parity_d = 1'b0;
            end else if (i_data) begin
                parity_d = ~parity_q;
            end else begin
                parity_d = parity_q;
            end

            // B and marks alternate; V deliberately repeats the last polarity.
            case (out_sym_s)
                SYM_MARK, SYM_B: begin
                    code_d     = pulse_code(~last_pol_q);
                    last_pol_d = ~last_pol_q;
                end
                SYM_V: begin
                    code_d = pulse_code(last_pol_q);
                end
                SYM_ZERO: begin
                    code_d = 2'b00;
                end
                default: begin
                    code_d = 2'b00;
                end
            endcase

            valid_d = (fill_q == 2'd3);
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p1_q       <= SYM_ZERO;
            p2_q       <= SYM_ZERO;
            p3_q       <= SYM_ZERO;
            fill_q     <= 2'd0;
            parity_q   <= 1'b0;
            last_pol_q <= INIT_LAST_POL;
            code_q     <= 2'b00;
            valid_q    <= 1'b0;
        end else begin
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            p3_q       <= p3_d;
            fill_q     <= fill_d;
            parity_q   <= parity_d;
            last_pol_q <= last_pol_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
        end
    end

    assign o_hdb3_code = code_q;
    assign o_valid     = valid_q;

endmodule

// File: tb/tb_hdb3_encoder.sv
// Directed testbench for hdb3_encoder with hand-computed expected symbols.
module tb_hdb3_encoder;

    logic       i_clk;
    logic       i_rst;
    logic       i_en;
    logic       i_data;
    logic [1:0] o_hdb3_code;
    logic       o_valid;

    int checks;
    int errors;

    hdb3_encoder dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_data      (i_data),
        .o_hdb3_code (o_hdb3_code),
        .o_valid     (o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [1:0] ec, input logic ev);
        checks++;
        assert ({o_hdb3_code, o_valid} === {ec, ev})
        else begin
            errors++;
            $error("FAIL %s: observed code=%b valid=%b expected code=%b valid=%b",
                   tag, o_hdb3_code, o_valid, ec, ev);
        end
    endtask

    task automatic send(input logic d, input logic [1:0] ec, input logic ev, input string tag);
        i_rst  = 1'b0;
        i_en   = 1'b1;
        i_data = d;
        @(posedge i_clk);
        #1;
        chk(tag, ec, ev);
    endtask

    task automatic idle(input logic [1:0] ec, input logic ev, input string tag);
        i_rst  = 1'b0;
        i_en   = 1'b0;
        i_data = 1'b1;
        @(posedge i_clk);
        #1;
        chk(tag, ec, ev);
    endtask

    task automatic do_reset(input string tag);
        i_rst  = 1'b1;
        i_en   = 1'b1;
        i_data = 1'b1;
        @(posedge i_clk);
        #1;
        chk(tag, 2'b00, 1'b0);
        i_rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst  = 1'b1;
        i_en   = 1'b0;
        i_data = 1'b0;
        @(posedge i_clk);
        #1;

        // Reset with enable and data high, then marks alternate polarity.
        do_reset("reset_init");
        send(1'b1, 2'b00, 1'b0, "marks_e1");
        send(1'b1, 2'b00, 1'b0, "marks_e2");
        send(1'b1, 2'b00, 1'b0, "marks_e3");
        send(1'b1, 2'b10, 1'b1, "marks_e4");
        send(1'b1, 2'b01, 1'b1, "marks_e5");
        send(1'b1, 2'b10, 1'b1, "marks_e6");
        // Mid-run reset: in-flight marks discarded, polarity back to initial.
        do_reset("reset_mid");
        send(1'b1, 2'b00, 1'b0, "rst_e1");
        send(1'b1, 2'b00, 1'b0, "rst_e2");
        send(1'b1, 2'b00, 1'b0, "rst_e3");
        send(1'b1, 2'b10, 1'b1, "rst_e4");
        send(1'b1, 2'b01, 1'b1, "rst_e5");
        send(1'b1, 2'b10, 1'b1, "rst_e6");
        send(1'b1, 2'b01, 1'b1, "rst_e7");

        // Odd parity: 1,0,0,0,0 -> + 0 0 0 V+
        do_reset("reset_odd");
        send(1'b1, 2'b00, 1'b0, "odd_e1");
        send(1'b0, 2'b00, 1'b0, "odd_e2");
        send(1'b0, 2'b00, 1'b0, "odd_e3");
        send(1'b0, 2'b10, 1'b1, "odd_e4");
        send(1'b0, 2'b00, 1'b1, "odd_e5");
        send(1'b1, 2'b00, 1'b1, "odd_e6");
        send(1'b1, 2'b00, 1'b1, "odd_e7");
        send(1'b1, 2'b10, 1'b1, "odd_e8");

        // Even parity: 1,1,0,0,0,0 -> + - B+ 0 0 V+
        do_reset("reset_even");
        send(1'b1, 2'b00, 1'b0, "even_e1");
        send(1'b1, 2'b00, 1'b0, "even_e2");
        send(1'b0, 2'b00, 1'b0, "even_e3");
        send(1'b0, 2'b10, 1'b1, "even_e4");
        send(1'b0, 2'b01, 1'b1, "even_e5");
        send(1'b0, 2'b10, 1'b1, "even_e6");
        send(1'b1, 2'b00, 1'b1, "even_e7");
        send(1'b1, 2'b00, 1'b1, "even_e8");
        send(1'b1, 2'b10, 1'b1, "even_e9");

        // Eight zeros after two marks: two B00V windows with opposite polarity.
        do_reset("reset_long");
        send(1'b1, 2'b00, 1'b0, "long_e1");
        send(1'b1, 2'b00, 1'b0, "long_e2");
        send(1'b0, 2'b00, 1'b0, "long_e3");
        send(1'b0, 2'b10, 1'b1, "long_e4");
        send(1'b0, 2'b01, 1'b1, "long_e5");
        send(1'b0, 2'b10, 1'b1, "long_e6");
        send(1'b0, 2'b00, 1'b1, "long_e7");
        send(1'b0, 2'b00, 1'b1, "long_e8");
        send(1'b0, 2'b10, 1'b1, "long_e9");
        send(1'b0, 2'b01, 1'b1, "long_e10");
        send(1'b1, 2'b00, 1'b1, "long_e11");
        send(1'b1, 2'b00, 1'b1, "long_e12");
        send(1'b1, 2'b01, 1'b1, "long_e13");

        // Even-parity sequence with idle gaps; outputs hold across gaps.
        do_reset("reset_stall");
        send(1'b1, 2'b00, 1'b0, "stall_e1");
        send(1'b1, 2'b00, 1'b0, "stall_e2");
        idle(2'b00, 1'b0, "stall_g2");
        send(1'b0, 2'b00, 1'b0, "stall_e3");
        send(1'b0, 2'b10, 1'b1, "stall_e4");
        idle(2'b10, 1'b1, "stall_g4");
        send(1'b0, 2'b01, 1'b1, "stall_e5");
        idle(2'b01, 1'b1, "stall_g5");
        send(1'b0, 2'b10, 1'b1, "stall_e6");
        idle(2'b10, 1'b1, "stall_g6a");
        idle(2'b10, 1'b1, "stall_g6b");
        send(1'b1, 2'b00, 1'b1, "stall_e7");
        idle(2'b00, 1'b1, "stall_g7");
        send(1'b1, 2'b00, 1'b1, "stall_e8");
        send(1'b1, 2'b10, 1'b1, "stall_e9");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdb3_encoder.md
# hdb3_encoder

Transmit-side HDB3 line encoder, the counterpart of the HDB3 decoder.
It converts a unipolar NRZ bit stream into bipolar HDB3 symbols on a two-rail {plus, minus} bus, using the same rail convention the decoder consumes.
It uses a three-stage symbol lookahead pipeline, a pulse-parity tracker and a last-polarity register, and sits between the framer's serial data output and the line driver.

## Interface
- INIT_LAST_POL, default 1'b0: reset value of the last-pulse-polarity register; 0 = minus, so the first pulse after reset is plus.
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_en  input  1  bit strobe; one NRZ bit is consumed per cycle with i_en=1; all state holds when 0.
- i_data  input  1  NRZ data bit, sampled when i_en=1.
- o_hdb3_code  output  2  [1]=plus rail, [0]=minus rail; 10 = +pulse, 01 = −pulse, 00 = zero; 11 is never driven. Registered.
- o_valid  output  1  high while o_hdb3_code holds a symbol derived from real input. Registered.

## Operation
- Symbol types (2-bit internal tag): ZERO, MARK, B, V.
- Pipeline p1 (newest), p2, p3 (oldest), then the output register. On each enable: p1<=incoming, p2<=p1, p3<=p2, and the output stage consumes old p3.
- Incoming tag: i_data=1 gives MARK; i_data=0 gives ZERO.
- Fill counter: 0..3, increments per enable, saturates at 3.
- Substitution condition, evaluated on an enable: fill==3, i_data=0, and p1, p2, p3 all ZERO.
  - The incoming symbol is tagged V into p1.
  - If parity is even, old p3 is retagged B as it enters the output stage. If parity is odd, it stays ZERO.
  - This gives B00V for even parity and 000V for odd parity.
- Parity register: 1 bit counting pulses entered since the last V.
  - Toggles on every enable with i_data=1.
  - Cleared to 0 on every substitution.
  - Substitution has priority; it cannot coincide with a toggle because it requires i_data=0.
- Output polarity, using last_pol:
  - MARK or B: emit the pulse opposite to last_pol, then last_pol <= emitted polarity.
  - V: emit the same polarity as last_pol; last_pol is unchanged.
  - ZERO: emit 00; last_pol is unchanged.
- o_valid is updated on each enable: o_valid <= (fill==3).
- After reset, pipeline contents are ZERO filler. They never trigger substitution because of the fill gate.

## Timing
- Reset (synchronous, i_rst=1 at an edge):
  - o_hdb3_code=00, o_valid=0.
  - p1..p3=ZERO, fill=0, parity=0, last_pol=INIT_LAST_POL.
- Reset wins over i_en. Reset mid-stream discards all in-flight symbols and parity.
- Latency: the bit sampled at enable edge k appears on o_hdb3_code after enable edge k+3 (4 enables). Idle cycles (i_en=0) stretch latency and hold all outputs.
- The first real symbol appears after the 4th enable following reset, with o_valid=1 from that edge on.
- A zero run of 4n bits produces n substitutions. A V is never reused as a zero of the next window.
- Consecutive V pulses always alternate polarity.
- Maximum zero run on the line is 3 symbols.
- No backpressure; one symbol out per enable.

## Test plan
- Reset: assert i_rst with i_en=1, i_data=1 -> o_hdb3_code=00, o_valid=0. After release, the first 3 enables keep o_valid=0.
- Marks: input 1,1,1,1 -> output 10,01,10,01 on enables 4-7, o_valid=1 from enable 4.
- Odd parity: input 1,0,0,0,0 -> output 10,00,00,00,10 (000V, V same as last +).
- Even parity: input 1,1,0,0,0,0 -> output 10,01,10,00,00,10 (B=+, V=+).
- Long zero run: input 1,1 then eight 0s -> 10,01, then B00V as 10,00,00,10, then B00V as 01,00,00,01. Parity is cleared between the two substitutions.
- Stall and reset: insert i_en=0 gaps mid-substitution -> sequence identical to the ungapped run, outputs held during gaps. Assert i_rst mid-run -> outputs 00 and o_valid 0 next edge; the next sequence starts from INIT_LAST_POL with first pulse 10.
